btn_debounce_oneshot: RTL and testbench

BTN_DEBOUNCE_ONESHOT -- requirements
Module: btn_debounce_oneshot

---
 rtl/btn_db_pkg.sv | 18 +
 rtl/sync_2ff.sv | 23 ++
 rtl/btn_debounce_oneshot.sv | 114 +++++++++++
 tb/tb_btn_debounce_oneshot.sv | 122 ++++++++++++
 4 files changed

// File: rtl/btn_db_pkg.sv
// Shared definitions for the button debounce / one-shot block.
// State encodings are kept here so other blocks can decode the FSM if needed.
package btn_db_pkg;

    // Debounce FSM states; all four 2-bit encodings are assigned.
    typedef enum logic [1:0] {
        IDLE_LO   = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } db_state_t;

    // Registered debounced level for a given state.
    function automatic logic state_level(input db_state_t s);
        return (s == STABLE_HI) || (s == WAIT_LO);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Reusable by any block that needs to bring a raw input into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw level through two flops; asynchronous clear to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce_oneshot.sv
// Button debouncer with optional rising-edge one-shot.
// btn_in is synchronized, then a four-state FSM requires DB_COUNT consecutive
// stable cycles before the debounced level x_out changes. Any reversal during
// qualification aborts it.
// Optional feature macro: BTN_DB_ONESHOT_EN -- when defined, pulse_out is a
// registered single-cycle strobe coincident with x_out rising; when undefined,
// pulse_out is tied to 0 and no edge-detect logic exists.
module btn_debounce_oneshot
    import btn_db_pkg::*;
#(
    parameter int DB_COUNT = 500000,
    parameter int CNT_W    = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic x_out,
    output logic pulse_out,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);

    logic             sync;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;
`ifdef BTN_DB_ONESHOT_EN
    logic             pulse_q;
`endif

    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn_in),
        .q       (sync)
    );

    // Debounce FSM with counter; x_out/busy/pulse are registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE_LO;
            cnt   <= '0;
            x_out <= 1'b0;
            busy  <= 1'b0;
`ifdef BTN_DB_ONESHOT_EN
            pulse_q <= 1'b0;
`endif
        end else begin
`ifdef BTN_DB_ONESHOT_EN
            pulse_q <= 1'b0;
`endif
            case (state)
                IDLE_LO: begin
                    if (sync) begin
                        state <= WAIT_HI;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (!sync) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        x_out <= 1'b1;
`ifdef BTN_DB_ONESHOT_EN
                        pulse_q <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!sync) begin
                        state <= WAIT_LO;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (sync) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        x_out <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_LO;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    x_out <= state_level(IDLE_LO);
                end
            endcase
        end
    end

`ifdef BTN_DB_ONESHOT_EN
    assign pulse_out = pulse_q;
`else
    assign pulse_out = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce_oneshot.sv
// Directed bench for btn_debounce_oneshot with DB_COUNT=4.
// Inputs change 1 time unit after a rising edge; edge e is the e-th rising
// edge after the change, and outputs are checked 1 time unit after it.
module tb_btn_debounce_oneshot;

    logic clk;
    logic reset_n;
    logic btn_in;
    logic x_out;
    logic pulse_out;
    logic busy;

    int checks;
    int errors;
    bit pulse_en;

    btn_debounce_oneshot #(
        .DB_COUNT (4),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_in    (btn_in),
        .x_out     (x_out),
        .pulse_out (pulse_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int e,
                              input logic ex, input logic eb, input logic ep);
        check($sformatf("%s e%0d x_out", tag, e), x_out, ex);
        check($sformatf("%s e%0d busy", tag, e), busy, eb);
        check($sformatf("%s e%0d pulse_out", tag, e), pulse_out, ep);
    endtask

    initial begin
        checks = 0;
        errors = 0;
`ifdef BTN_DB_ONESHOT_EN
        pulse_en = 1'b1;
`else
        pulse_en = 1'b0;
`endif
        reset_n = 1'b0;
        btn_in  = 1'b0;
        #2;
        check_outs("reset", 0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_outs("idle", 0, 1'b0, 1'b0, 1'b0);

        // Clean press: x_out on edge 7, busy edges 3-6, pulse edge 7 only.
        btn_in = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            check_outs("press", e, e >= 7, (e >= 3) && (e <= 6), pulse_en && (e == 7));
        end

        // Release: x_out falls on edge 7, pulse never set.
        btn_in = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            check_outs("release", e, e < 7, (e >= 3) && (e <= 6), 1'b0);
        end

        // Bounce: high 2, low 1, then held high (final rise sampled at edge 4).
        for (int e = 1; e <= 11; e++) begin
            btn_in = (e == 3) ? 1'b0 : 1'b1;
            tick();
            check_outs("bounce", e, e >= 10,
                       (e == 3) || (e == 4) || ((e >= 6) && (e <= 9)),
                       pulse_en && (e == 10));
        end
        btn_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_outs("bounce_rel", 0, 1'b0, 1'b0, 1'b0);

        // One-cycle glitch: busy only after edge 3, x_out stays low.
        for (int e = 1; e <= 8; e++) begin
            btn_in = (e == 1) ? 1'b1 : 1'b0;
            tick();
            check_outs("glitch", e, 1'b0, e == 3, 1'b0);
        end

        // Reset mid-count during WAIT_HI, then requalify from reset release.
        btn_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_outs("pre_rst", 4, 1'b0, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        check_outs("mid_rst", 0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("mid_rst_hold", 0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            check_outs("post_rst", e, e >= 7, (e >= 3) && (e <= 6), pulse_en && (e == 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
